sb_stream_incr: RTL and testbench



---
 rtl/sb_stream_incr.sv | 113 +++++++++++
 tb/tb_sb_stream_incr.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_stream_incr.sv
// Registered two-entry streaming stage: adds INCR to the low 64 data bits,
// passes all-ones terminator beats through untouched, counts packets, flags done.
module sb_stream_incr #(
  parameter int          DW   = 256,
  parameter int          AW   = 32,
  parameter logic [63:0] INCR = 64'd42,
  parameter int          CW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_dest,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_dest,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] pkt_count,
  output logic          done
);

  logic          acc_in;
  logic          acc_out;
  logic          in_term;
  logic [DW-1:0] in_xform;

  logic [DW-1:0] skid_data;
  logic [AW-1:0] skid_dest;
  logic          skid_last;
  logic          skid_term;
  logic          skid_valid;
  logic          main_term;
  logic          stop;

  logic          skid_valid_n;
  logic          stop_n;

  assign acc_in  = in_valid && in_ready;
  assign acc_out = out_valid && out_ready;
  assign in_term = &in_data;

  always_comb begin
    in_xform = in_data;
    if (!in_term) in_xform[63:0] = in_data[63:0] + INCR;
  end

  // in_ready is registered from the next-state skid/stop so it is low during rst
  // and never depends combinationally on out_ready.
  always_comb begin
    skid_valid_n = skid_valid;
    if (skid_valid && acc_out)
      skid_valid_n = 1'b0;
    else if (acc_in && out_valid && !out_ready)
      skid_valid_n = 1'b1;
    stop_n = stop || (acc_in && in_term);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_dest   <= '0;
      out_last   <= 1'b0;
      main_term  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_dest  <= '0;
      skid_last  <= 1'b0;
      skid_term  <= 1'b0;
      stop       <= 1'b0;
      done       <= 1'b0;
      pkt_count  <= '0;
    end else begin
      in_ready   <= !skid_valid_n && !stop_n;
      skid_valid <= skid_valid_n;
      stop       <= stop_n;

      if (acc_out) begin
        if (out_last)  pkt_count <= pkt_count + CW'(1);
        if (main_term) done      <= 1'b1;
        if (skid_valid) begin
          out_data  <= skid_data;
          out_dest  <= skid_dest;
          out_last  <= skid_last;
          main_term <= skid_term;
        end else begin
          out_valid <= 1'b0;
        end
      end

      // A skid drain and an input accept never coincide: in_ready is low while skid is full.
      if (acc_in) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_data  <= in_xform;
          out_dest  <= in_dest;
          out_last  <= in_last;
          main_term <= in_term;
        end else begin
          skid_data <= in_xform;
          skid_dest <= in_dest;
          skid_last <= in_last;
          skid_term <= in_term;
        end
      end
    end
  end

endmodule

// File: tb/tb_sb_stream_incr.sv
// Directed self-checking bench for sb_stream_incr.
module tb_sb_stream_incr;
  localparam int DW = 256;
  localparam int AW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_dest = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_dest;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] pkt_count;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  sb_stream_incr #(.DW(DW), .AW(AW), .INCR(64'd42), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .pkt_count(pkt_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input logic [63:0] v);
    logic [DW-1:0] d;
    d = '0;
    d[63:0] = v;
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (pkt_count !== '0) begin n_err++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (out_data !== '0 || out_dest !== '0 || out_last !== 1'b0) begin
      n_err++; $display("FAIL reset_out_fields data=%h dest=%h last=%b exp=0", out_data, out_dest, out_last);
    end
    rst = 1'b0;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_data = mk(64'd5); in_dest = 32'd7; in_last = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== mk(64'd47) || out_dest !== 32'd7 || out_last !== 1'b1) begin
      n_err++; $display("FAIL single_beat valid=%b data=%h dest=%0d last=%b exp 1/47/7/1", out_valid, out_data, out_dest, out_last);
    end
    step();
    n_cmp++; if (pkt_count !== 32'd1) begin n_err++; $display("FAIL single_pkt_count got=%0d exp=1", pkt_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_d;
    exp_d = {{24{8'hAB}}, 64'h0000_0000_0000_000A};
    in_data = {{24{8'hAB}}, 64'hFFFF_FFFF_FFFF_FFE0}; in_dest = 32'h55; in_last = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d || out_dest !== 32'h55) begin
      n_err++; $display("FAIL wrap_data valid=%b data=%h dest=%h exp data=%h", out_valid, out_data, out_dest, exp_d);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [63:0] got [4];
    int n;
    int sent;
    bit acc;
    out_ready = 1'b0;
    in_dest = 32'd3; in_last = 1'b0;
    in_data = mk(64'd1); in_valid = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_1 got=%b exp=1", in_ready); end
    in_data = mk(64'd2);
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_after_2 got=%b exp=0", in_ready); end
    in_data = mk(64'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== mk(64'd43) || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_stall_stable valid=%b data=%h ready=%b exp 1/43/0", out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    n = 0; sent = 2;
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      if (out_valid && out_ready) begin got[n] = out_data[63:0]; n++; end
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        sent++;
        if (sent < 4) in_data = mk(64'(sent + 1));
        else in_valid = 1'b0;
      end
    end
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL bp_out_count got=%0d exp=4", n); end
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (got[i] !== 64'(43 + i)) begin n_err++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, got[i], 43 + i); end
    end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int nout;
    int nin;
    int edges;
    bit acc;
    bit xfer;
    out_ready = 1'b1;
    nin = 0; nout = 0; edges = 0;
    in_data = mk(64'd100); in_last = 1'b0; in_dest = 32'd1; in_valid = 1'b1;
    while (nout < 100 && edges < 300) begin
      xfer = out_valid && out_ready;
      if (xfer) begin
        n_cmp++; if (out_data !== mk(64'(142 + nout)) || out_last !== ((nout % 10) == 9)) begin
          n_err++; $display("FAIL b2b_beat idx=%0d data=%h last=%b exp data=%0d", nout, out_data, out_last, 142 + nout);
        end
        nout++;
      end
      acc = in_valid && in_ready;
      step();
      edges++;
      if (acc) begin
        nin++;
        if (nin < 100) begin
          in_data = mk(64'(100 + nin));
          in_last = ((nin % 10) == 9);
        end else begin
          in_valid = 1'b0; in_last = 1'b0;
        end
      end
    end
    n_cmp++; if (edges !== 101) begin n_err++; $display("FAIL b2b_cycles got=%0d exp=101", edges); end
    n_cmp++; if (pkt_count !== 32'd11) begin n_err++; $display("FAIL b2b_pkt_count got=%0d exp=11", pkt_count); end
  endtask

  task automatic test_terminator();
    logic [DW-1:0] got [4];
    logic [DW-1:0] ones;
    int n;
    int bi;
    bit acc;
    bit term_xfer;
    ones = '1;
    out_ready = 1'b1;
    n = 0; bi = 0;
    in_data = mk(64'd10); in_dest = 32'd2; in_last = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
      term_xfer = 1'b0;
      if (out_valid && out_ready) begin
        got[n] = out_data;
        if (n == 3) begin
          term_xfer = 1'b1;
          n_cmp++; if (out_dest !== 32'd9 || out_last !== 1'b1) begin
            n_err++; $display("FAIL term_fields dest=%0d last=%b exp 9/1", out_dest, out_last);
          end
          n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL term_done_early got=%b exp=0", done); end
        end
        n++;
      end
      acc = in_valid && in_ready;
      step();
      if (term_xfer) begin
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL term_done got=%b exp=1", done); end
      end
      if (acc) begin
        bi++;
        if (bi < 3) in_data = mk(64'(10 + bi));
        else if (bi == 3) begin in_data = ones; in_dest = 32'd9; in_last = 1'b1; end
        else begin in_data = mk(64'd77); in_dest = 32'd4; in_last = 1'b1; end
      end
    end
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL term_out_count got=%0d exp=4", n); end
    for (int i = 0; i < 3 && i < n; i++) begin
      n_cmp++; if (got[i] !== mk(64'(52 + i))) begin n_err++; $display("FAIL term_pre_beat idx=%0d got=%h exp=%0d", i, got[i], 52 + i); end
    end
    if (n == 4) begin
      n_cmp++; if (got[3] !== ones) begin n_err++; $display("FAIL term_unmodified got=%h exp=all ones", got[3]); end
    end
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL term_stopped in_ready=%b out_valid=%b exp 0/0", in_ready, out_valid);
    end
    n_cmp++; if (pkt_count !== 32'd12) begin n_err++; $display("FAIL term_pkt_count got=%0d exp=12", pkt_count); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL term_done_sticky got=%b exp=1", done); end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b0;
    in_dest = 32'd6; in_last = 1'b1;
    in_data = mk(64'd1); in_valid = 1'b1;
    step();
    in_data = mk(64'd2);
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL rmid_held out_valid=%b in_ready=%b exp 1/0", out_valid, in_ready);
    end
    rst = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || pkt_count !== '0 || done !== 1'b0) begin
      n_err++; $display("FAIL rmid_cleared out_valid=%b pkt_count=%0d done=%b exp 0/0/0", out_valid, pkt_count, done);
    end
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    in_data = mk(64'd0); in_last = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== mk(64'd42)) begin
      n_err++; $display("FAIL rmid_first_beat valid=%b data=%h exp 1/42", out_valid, out_data);
    end
    step();
    n_cmp++; if (out_valid !== 1'b0 || pkt_count !== '0) begin
      n_err++; $display("FAIL rmid_no_stale valid=%b pkt_count=%0d exp 0/0", out_valid, pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_terminator();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
